// File: rtl/cnn_mac_pkg.sv
// Shared configuration and rescale helpers for the pipelined CNN multiply-accumulate unit.
package cnn_mac_pkg;

  typedef struct packed {
    int a_w;
    int b_w;
    int acc_w;
    int out_w;
    int cnt_w;
    int num_stage;
  } mac_cfg_t;

  localparam mac_cfg_t MAC_CFG_DEF = '{a_w: 9, b_w: 14, acc_w: 32, out_w: 16, cnt_w: 8, num_stage: 2};
  localparam int P_W = MAC_CFG_DEF.a_w + MAC_CFG_DEF.b_w;

  // Rounding is done at 64 bits so the half-LSB bias can never wrap the accumulator.
  function automatic logic signed [63:0] shift_round(input logic signed [63:0] acc,
                                                     input int frac_shift,
                                                     input logic rnd);
    logic signed [63:0] r;
    r = acc;
    if (rnd && frac_shift > 0) r = acc + (64'sd1 <<< (frac_shift - 1));
    return r >>> frac_shift;
  endfunction

  function automatic logic sat_flag(input logic signed [63:0] s, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    return (s > hi) || (s < lo);
  endfunction

  function automatic logic signed [63:0] sat_value(input logic signed [63:0] s,
                                                   input int out_w,
                                                   input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (!sat) return s;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/cnn_mac_pipe_mul.sv
// Signed A_W x B_W multiplier with NUM_STAGE clock-enabled pipeline registers and a matching valid shift.
module cnn_mac_mul_pipe #(
  parameter int A_W       = 9,
  parameter int B_W       = 14,
  parameter int NUM_STAGE = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic signed [A_W-1:0]       din0,
  input  logic signed [B_W-1:0]       din1,
  output logic signed [A_W+B_W-1:0]   prod,
  output logic                        prod_valid,
  output logic                        pipe_busy
);

  localparam int PW = A_W + B_W;

  logic signed [PW-1:0] p_q [NUM_STAGE];
  logic [NUM_STAGE-1:0] v_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else if (ce) begin
      v_q[0] <= in_valid;
      for (int unsigned i = 1; i < NUM_STAGE; i++) v_q[i] <= v_q[i-1];
    end
  end

  // Data registers carry no reset so they can fold into the DSP's internal pipeline.
  always_ff @(posedge clk) begin
    if (ce) begin
      p_q[0] <= PW'(din0) * PW'(din1);
      for (int unsigned i = 1; i < NUM_STAGE; i++) p_q[i] <= p_q[i-1];
    end
  end

  assign prod       = p_q[NUM_STAGE-1];
  assign prod_valid = v_q[NUM_STAGE-1];
  assign pipe_busy  = |v_q;

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate: multiplier pipe, grouped accumulate, rescale/saturate output.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = MAC_CFG_DEF.a_w,
  parameter int B_W        = MAC_CFG_DEF.b_w,
  parameter int ACC_W      = MAC_CFG_DEF.acc_w,
  parameter int OUT_W      = MAC_CFG_DEF.out_w,
  parameter int CNT_W      = MAC_CFG_DEF.cnt_w,
  parameter int NUM_STAGE  = MAC_CFG_DEF.num_stage,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  input  logic [CNT_W-1:0]        acc_len,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic                    out_sat,
  output logic                    busy
);

  localparam int PROD_W = A_W + B_W;

  if (ACC_W < PROD_W || ACC_W > 63 || NUM_STAGE < 1 || NUM_STAGE > 4 || OUT_W > 63) begin : g_bad_cfg
    $error("cnn_mac_pipe: illegal parameter combination");
  end

  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;
  logic                     pipe_busy;

  cnn_mac_mul_pipe #(
    .A_W      (A_W),
    .B_W      (B_W),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .din0      (din0),
    .din1      (din1),
    .prod      (prod),
    .prod_valid(prod_valid),
    .pipe_busy (pipe_busy)
  );

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        len_q;
  logic [CNT_W-1:0]        len_cur;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic                    acc_valid;
  logic                    last;

  // A group's length is fixed when its first product arrives; later acc_len changes wait for the next group.
  always_comb begin
    len_cur = len_q;
    if (cnt == '0) len_cur = (acc_len == '0) ? CNT_W'(1) : acc_len;
    last     = (cnt == len_cur - CNT_W'(1));
    acc_next = (cnt == '0) ? ACC_W'(prod) : acc + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      len_q     <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
    end else if (ce) begin
      acc_valid <= prod_valid && last;
      if (prod_valid) begin
        acc   <= acc_next;
        len_q <= len_cur;
        cnt   <= last ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  logic signed [63:0] scaled;

  always_comb scaled = shift_round(64'(acc), FRAC_SHIFT, ROUND != 0);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
    end else if (ce) begin
      out_valid <= acc_valid;
      if (acc_valid) begin
        dout    <= OUT_W'(sat_value(scaled, OUT_W, SAT != 0));
        out_sat <= (SAT != 0) && sat_flag(scaled, OUT_W);
      end
    end
  end

  assign busy = (cnt != '0) || pipe_busy || acc_valid;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Randomized and directed checks of cnn_mac_pipe in three configurations against a group-sum reference model.
module tb_cnn_mac_pipe;

  logic clk = 1'b0;
  logic reset, ce, in_valid;
  logic signed [8:0]  din0;
  logic signed [13:0] din1;
  logic [7:0] acc_len;

  logic               ov [3];
  logic signed [15:0] dv [3];
  logic               sv [3];
  logic               bz [3];

  always #5 clk = ~clk;

  cnn_mac_pipe #(.NUM_STAGE(2), .FRAC_SHIFT(0), .ROUND(0), .SAT(1)) u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_len(acc_len), .out_valid(ov[0]), .dout(dv[0]), .out_sat(sv[0]), .busy(bz[0]));

  cnn_mac_pipe #(.NUM_STAGE(1), .FRAC_SHIFT(4), .ROUND(1), .SAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_len(acc_len), .out_valid(ov[1]), .dout(dv[1]), .out_sat(sv[1]), .busy(bz[1]));

  cnn_mac_pipe #(.NUM_STAGE(4), .FRAC_SHIFT(4), .ROUND(0), .SAT(0)) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_len(acc_len), .out_valid(ov[2]), .dout(dv[2]), .out_sat(sv[2]), .busy(bz[2]));

  localparam int NS   [3] = '{2, 1, 4};
  localparam int FSH  [3] = '{0, 4, 4};
  localparam int RND  [3] = '{0, 1, 0};
  localparam int SATC [3] = '{1, 1, 0};

  typedef struct { int due; int d; int s; } exp_t;
  typedef struct { int d; int s; int cyc; } seen_t;

  exp_t  eq [3][256];
  int    head [3];
  int    tail [3];
  int    last_d [3];
  seen_t seen0[$], seen1[$], seen2[$];

  int     n_assert = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     ecnt = 0;
  bit     armed = 0;
  int     gcnt = 0;
  int     glen = 1;
  longint gsum = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Group sum wrapped to 32 bits, then rounded, arithmetically shifted and clipped or wrapped to 16 bits.
  function automatic void expect_out(input longint sum, input int i, output int d, output int s);
    longint a;
    a = longint'(int'(sum));
    if (RND[i] != 0 && FSH[i] > 0) a = a + (longint'(1) << (FSH[i] - 1));
    a = a >>> FSH[i];
    s = 0;
    if (SATC[i] != 0) begin
      if (a > 32767) begin a = 32767; s = 1; end
      else if (a < -32768) begin a = -32768; s = 1; end
      d = int'(a);
    end else begin
      d = int'(16'(a));
      if (d > 32767) d = d - 65536;
    end
  endfunction

  task automatic model_loop();
    int d, s;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        gcnt = 0;
        gsum = 0;
        for (int i = 0; i < 3; i++) tail[i] = head[i];
      end else if (ce) begin
        ecnt++;
        if (in_valid) begin
          if (gcnt == 0) glen = (acc_len == 0) ? 1 : int'(acc_len);
          gsum = gsum + longint'(din0) * longint'(din1);
          gcnt++;
          if (gcnt == glen) begin
            for (int i = 0; i < 3; i++) begin
              expect_out(gsum, i, d, s);
              eq[i][tail[i] % 256] = '{due: ecnt + NS[i] + 1, d: d, s: s};
              tail[i]++;
            end
            gcnt = 0;
            gsum = 0;
          end
        end
      end
    end
  endtask

  task automatic monitor();
    bit   due_now;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < 3; i++) last_d[i] = 0;
        armed = 1;
        continue;
      end
      if (!armed) continue;
      for (int i = 0; i < 3; i++) begin
        e = eq[i][head[i] % 256];
        due_now = (head[i] != tail[i]) && (e.due == ecnt);
        chk($sformatf("out_valid[%0d]", i), longint'(ov[i]), longint'(due_now));
        if (due_now) begin
          chk($sformatf("dout[%0d]", i), longint'(dv[i]), longint'(e.d));
          chk($sformatf("out_sat[%0d]", i), longint'(sv[i]), longint'(e.s));
          if (ce) begin
            last_d[i] = e.d;
            case (i)
              0: seen0.push_back('{d: int'(dv[i]), s: int'(sv[i]), cyc: cyc});
              1: seen1.push_back('{d: int'(dv[i]), s: int'(sv[i]), cyc: cyc});
              default: seen2.push_back('{d: int'(dv[i]), s: int'(sv[i]), cyc: cyc});
            endcase
            head[i]++;
          end
        end else begin
          chk($sformatf("dout_hold[%0d]", i), longint'(dv[i]), longint'(last_d[i]));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, output int c);
    in_valid = 1'b1;
    din0 = 9'(a);
    din1 = 14'(b);
    @(posedge clk);
    #1;
    c = cyc;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    ce = 1'b1;
    repeat (n) step();
  endtask

  task automatic clear_seen();
    seen0.delete();
    seen1.delete();
    seen2.delete();
  endtask

  initial begin
    int c0, c1, c2, c3;
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0; acc_len = 8'd1;
    for (int i = 0; i < 3; i++) begin head[i] = 0; tail[i] = 0; last_d[i] = 0; end
    fork
      model_loop();
      monitor();
    join_none
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset out_valid", longint'(ov[i]), 0);
      chk("reset dout", longint'(dv[i]), 0);
      chk("reset out_sat", longint'(sv[i]), 0);
      chk("reset busy", longint'(bz[i]), 0);
    end

    // single saturating product and its latency
    clear_seen(); acc_len = 8'd1;
    drive(-256, 8191, c0);
    idle(8);
    chk("t1 count", seen0.size(), 1);
    if (seen0.size() == 1) begin
      chk("t1 dout", seen0[0].d, -32768);
      chk("t1 sat", seen0[0].s, 1);
      chk("t1 latency", seen0[0].cyc - c0, 3);
    end

    // three-term group
    clear_seen(); acc_len = 8'd3;
    drive(3, 100, c0);
    chk("t2 busy mid", longint'(bz[0]), 1);
    drive(-2, 50, c1);
    drive(7, -10, c2);
    idle(8);
    chk("t2 count", seen0.size(), 1);
    if (seen0.size() == 1) begin
      chk("t2 dout", seen0[0].d, 130);
      chk("t2 sat", seen0[0].s, 0);
      chk("t2 latency", seen0[0].cyc - c0, 5);
    end
    chk("t2 busy after", longint'(bz[0]), 0);

    // same group with ce held low for three cycles mid-stream
    clear_seen();
    drive(3, 100, c0);
    drive(-2, 50, c1);
    ce = 1'b0; in_valid = 1'b1; din0 = 9'sd100; din1 = 14'sd100;
    repeat (3) step();
    ce = 1'b1;
    drive(7, -10, c2);
    idle(10);
    chk("t4 count", seen0.size(), 1);
    if (seen0.size() == 1) begin
      chk("t4 dout", seen0[0].d, 130);
      chk("t4 latency", seen0[0].cyc - c0, 8);
    end

    // back-to-back two-term groups
    clear_seen(); acc_len = 8'd2;
    drive(1, 1, c0); drive(2, 2, c1); drive(3, 3, c2); drive(4, 4, c3);
    idle(8);
    chk("t3 count", seen0.size(), 2);
    if (seen0.size() == 2) begin
      chk("t3 dout0", seen0[0].d, 5);
      chk("t3 dout1", seen0[1].d, 25);
      chk("t3 spacing", seen0[1].cyc - seen0[0].cyc, 2);
    end

    // reset aborts a partial group
    clear_seen(); acc_len = 8'd4;
    drive(5, 5, c0); drive(6, 6, c1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5 busy after reset", longint'(bz[0]), 0);
    acc_len = 8'd1;
    drive(5, 5, c2);
    idle(8);
    chk("t5 count", seen0.size(), 1);
    if (seen0.size() == 1) chk("t5 dout", seen0[0].d, 25);

    // acc_len change after a group has started is deferred to the next group
    clear_seen(); acc_len = 8'd3;
    drive(2, 3, c0);
    idle(6);
    acc_len = 8'd1;
    drive(4, 5, c1); drive(1, 1, c2);
    idle(8);
    chk("len hold count", seen0.size(), 1);
    if (seen0.size() == 1) chk("len hold dout", seen0[0].d, 27);

    // fractional shift with and without rounding
    clear_seen(); acc_len = 8'd1;
    drive(3, 8, c0); drive(-3, 8, c1); drive(1, 8, c2);
    idle(10);
    chk("t6 round count", seen1.size(), 3);
    if (seen1.size() == 3) begin
      chk("t6 round a", seen1[0].d, 2);
      chk("t6 round b", seen1[1].d, -1);
      chk("t6 round c", seen1[2].d, 1);
    end
    chk("t6 trunc count", seen2.size(), 3);
    if (seen2.size() == 3) begin
      chk("t6 trunc a", seen2[0].d, 1);
      chk("t6 trunc b", seen2[1].d, -2);
    end

    // randomized segments; acc_len changes only after the pipeline has drained
    for (int seg = 0; seg < 40; seg++) begin
      acc_len = 8'($urandom_range(0, 8));
      repeat ($urandom_range(20, 60)) begin
        ce       = ($urandom_range(0, 99) < 85);
        in_valid = ($urandom_range(0, 99) < 70);
        reset    = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 4) == 0) begin
          din0 = $urandom_range(0, 1) ? -9'sd256 : 9'sd255;
          din1 = $urandom_range(0, 1) ? -14'sd8192 : 14'sd8191;
        end else begin
          din0 = 9'($urandom);
          din1 = 14'($urandom);
        end
        step();
      end
      reset = 1'b0;
      idle(12);
    end

    idle(12);
    for (int i = 0; i < 3; i++) chk($sformatf("drained[%0d]", i), head[i], tail[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_mac_pipe.md
Name: cnn_mac_pipe

Overview:
Pipelined, parametrised signed multiply-accumulate unit. It is the next generation of the fixed 9x14 combinational DSP48 multiplier in the CNN datapath. It multiplies a stream of signed operand pairs and accumulates a run-time-programmable number of products per output, for example one conv kernel window. Each result is rescaled, optionally rounded and saturated, then emitted with a valid pulse. It sits between the weight/feature-map fetch logic and the activation/pooling stage.

Parameters:
A_W, 9, width of signed operand din0
B_W, 14, width of signed operand din1
ACC_W, 32, accumulator width; must be >= A_W+B_W
OUT_W, 16, width of signed result dout
CNT_W, 8, width of acc_len
NUM_STAGE, 2, multiplier pipeline registers, legal 1..4
FRAC_SHIFT, 0, arithmetic right shift applied to the accumulator before output
ROUND, 0, 1 = round half toward +inf before the shift drops bits
SAT, 1, 1 = saturate to OUT_W; 0 = wrap (truncate)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; when low every register holds
in_valid  in  1  din0/din1 carry a valid term this cycle
din0  in  A_W  signed operand
din1  in  B_W  signed operand
acc_len  in  CNT_W  products per output; sampled on the first term of each group
out_valid  out  1  one-cycle pulse, dout valid
dout  out  OUT_W  signed result
out_sat  out  1  qualifies out_valid; 1 = saturation clipped this result
busy  out  1  a group is partially accumulated or results are in flight

Behaviour:
- Reset: clk-synchronous, active-high; dominates ce. out_valid=0, dout=0, out_sat=0, busy=0; term counter=0; accumulator=0; all pipeline valid bits=0.
- ce=0: no register updates, including valids and the counter. Terms presented while ce=0 are ignored.
- Stage chain, all gated by ce:
  - NUM_STAGE multiplier registers. Product width A_W+B_W, fully signed, sign-extended to ACC_W.
  - One accumulate stage.
  - One output/rescale stage.
- Latency: the last term of a group, accepted at edge k, gives out_valid=1 in the cycle after edge k+NUM_STAGE+1, i.e. NUM_STAGE+2 enabled cycles.
- Group control, at the accumulate stage:
  - Counter 0 marks a group start. acc_len is latched at that point; acc_len=0 is treated as 1.
  - First product of a group: acc <= product, not acc+product. This allows back-to-back groups with no bubble.
  - On the product where counter==len-1: counter<=0 and a result is passed to the output stage. Otherwise the counter increments.
  - Changing acc_len mid-group has no effect until the next group.
- Accumulator overflow wraps modulo 2^ACC_W. Sizing ACC_W is the integrator's responsibility.
- Output stage:
  - If ROUND=1 and FRAC_SHIFT>0: r = acc + 2^(FRAC_SHIFT-1). Otherwise r = acc.
  - s = r >>> FRAC_SHIFT (arithmetic shift).
  - SAT=1: clip s to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 if clipped. SAT=0: dout = s[OUT_W-1:0], out_sat=0.
- out_valid pulses for exactly one enabled cycle. dout holds its last value until the next out_valid.
- busy = counter!=0 OR any pipeline valid bit set.
- in_valid gaps inside a group are allowed; the group simply waits for more terms.
- A reset mid-group discards the partial sum and all in-flight results; no out_valid follows.

Decomposition:
- Package cnn_mac_pkg: mac_cfg_t constants (default widths), a sat/round helper function, and the localparam P_W=A_W+B_W.
- One sub-module, cnn_mac_mul_pipe: signed A_W x B_W multiplier with NUM_STAGE ce-gated registers and a valid shift. It is shaped to infer a DSP48 with internal pipeline registers.
- Counter, accumulator and rescale logic stay in the top.

Test Plan:
1. Defaults, acc_len=1, din0=-256, din1=8191 -> product -2096896; dout=-32768, out_sat=1; out_valid exactly 4 cycles after acceptance.
2. acc_len=3, terms (3,100),(-2,50),(7,-10) on consecutive cycles -> single out_valid, dout=130, out_sat=0, busy low after it.
3. acc_len=2, continuous terms (1,1),(2,2),(3,3),(4,4) -> out_valid on two consecutive-group results, dout=5 then 25, no bubble.
4. Case 2 with ce=0 for 3 cycles mid-stream -> same dout=130, out_valid delayed by exactly 3 cycles, no duplicate pulse.
5. acc_len=4, two terms (5,5),(6,6), reset for 1 cycle, then acc_len=1 with (5,5) -> only out_valid has dout=25; none for the aborted group.
6. FRAC_SHIFT=4, ROUND=1, acc_len=1: (3,8) -> dout=2; (-3,8) -> dout=-1; (1,8) -> dout=1. With ROUND=0: (3,8) -> 1 and (-3,8) -> -2.
